// File: rtl/pacman_pkg.sv
// Shared ghost-control types: mode encoding, direction codes and LFSR taps.
package pacman_pkg;

  typedef enum logic [1:0] {
    GM_IDLE    = 2'd0,
    GM_SCATTER = 2'd1,
    GM_CHASE   = 2'd2,
    GM_FRIGHT  = 2'd3
  } ghost_mode_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Right-shifting Galois taps for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    case (d)
      DIR_UP:   dir_reverse = DIR_DOWN;
      DIR_DOWN: dir_reverse = DIR_UP;
      DIR_LEFT: dir_reverse = DIR_RIGHT;
      default:  dir_reverse = DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, steps every Clk; a zero state is replaced by seed on the next Clk.
module lfsr16
  import pacman_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q <= seed;
    end else if (q == 16'h0000) begin
      q <= seed;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
    end
  end

endmodule

// File: rtl/ghost_director.sv
// Ghost scatter/chase/fright scheduler plus per-frame random directions; outputs land 3-4 Clk after frame_clk rises.
// No backpressure: ggShow stalls everything but the LFSR. GHOST_DIR_FREEZE_WARN_EN enables freeze_warn.
module ghost_director
  import pacman_pkg::*;
#(
  parameter logic [9:0]  SCATTER_FRAMES = 10'd420,
  parameter logic [9:0]  CHASE_FRAMES   = 10'd900,
  parameter logic [9:0]  FREEZE_FRAMES  = 10'd360,
  parameter logic [9:0]  WARN_FRAMES    = 10'd90,
  parameter logic [2:0]  AI_LEVEL       = 3'd5,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start,
  input  logic       super_dot,
  input  logic       ggShow,
  output logic [7:0] rnd_dir,
  output logic [2:0] AIpercent,
  output logic       freeze,
  output logic       freeze_warn,
  output logic [1:0] mode
);

  if (SCATTER_FRAMES == 10'd0 || CHASE_FRAMES == 10'd0 || FREEZE_FRAMES == 10'd0 ||
      WARN_FRAMES >= FREEZE_FRAMES || LFSR_SEED == 16'h0000) begin : g_cfg_bad
    $error("ghost_director: invalid frame/seed parameters");
  end

  logic [15:0] lfsr_q;
  logic [2:0]  fsync;
  logic        tick, consume;
  logic        sd_q, pending, pending_n;

  ghost_mode_t state, state_n, sv_mode, sv_mode_n, ph_mode;
  logic [9:0]  cnt, cnt_n, fcnt, fcnt_n, sv_cnt, sv_cnt_n, ph_cnt;
  logic [7:0]  rnd_n;
  logic [2:0]  ai_n;
  logic        freeze_n;

  lfsr16 u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign tick    = fsync[1] & ~fsync[2];
  assign consume = tick & ~ggShow;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fsync   <= 3'b000;
      sd_q    <= 1'b0;
      pending <= 1'b0;
    end else begin
      fsync   <= {fsync[1:0], frame_clk};
      sd_q    <= super_dot;
      pending <= pending_n;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= GM_IDLE;
      cnt       <= 10'd0;
      fcnt      <= 10'd0;
      sv_mode   <= GM_IDLE;
      sv_cnt    <= 10'd0;
      rnd_dir   <= 8'd0;
      AIpercent <= 3'd0;
      freeze    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      fcnt      <= fcnt_n;
      sv_mode   <= sv_mode_n;
      sv_cnt    <= sv_cnt_n;
      rnd_dir   <= rnd_n;
      AIpercent <= ai_n;
      freeze    <= freeze_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    fcnt_n    = fcnt;
    sv_mode_n = sv_mode;
    sv_cnt_n  = sv_cnt;
    ph_mode   = state;
    ph_cnt    = cnt;
    rnd_n     = rnd_dir;
    pending_n = pending;

    // A new edge outranks consumption so a press on the tick cycle is not lost.
    if (super_dot && !sd_q) begin
      pending_n = 1'b1;
    end else if (consume) begin
      pending_n = 1'b0;
    end

    if (consume) begin
      rnd_n = lfsr_q[7:0];
      case (state)
        GM_IDLE: begin
          if (start) begin
            state_n = GM_SCATTER;
            cnt_n   = SCATTER_FRAMES - 10'd1;
          end
        end
        GM_SCATTER, GM_CHASE: begin
          if (cnt == 10'd0) begin
            ph_mode = (state == GM_SCATTER) ? GM_CHASE : GM_SCATTER;
            ph_cnt  = (state == GM_SCATTER) ? CHASE_FRAMES - 10'd1 : SCATTER_FRAMES - 10'd1;
          end else begin
            ph_cnt = cnt - 10'd1;
          end
          // Fright saves the post-tick phase, so expiry on this tick resumes the new phase in full.
          if (pending) begin
            sv_mode_n = ph_mode;
            sv_cnt_n  = ph_cnt;
            state_n   = GM_FRIGHT;
            fcnt_n    = FREEZE_FRAMES - 10'd1;
          end else begin
            state_n = ph_mode;
            cnt_n   = ph_cnt;
          end
        end
        default: begin
          if (pending) begin
            fcnt_n = FREEZE_FRAMES - 10'd1;
          end else if (fcnt == 10'd0) begin
            state_n = sv_mode;
            cnt_n   = sv_cnt;
          end else begin
            fcnt_n = fcnt - 10'd1;
          end
        end
      endcase
    end

    ai_n     = (state_n == GM_CHASE) ? AI_LEVEL : 3'd0;
    freeze_n = (state_n == GM_FRIGHT);
  end

`ifdef GHOST_DIR_FREEZE_WARN_EN
  logic warn_n;

  assign warn_n = (state_n == GM_FRIGHT) && (fcnt_n < WARN_FRAMES);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      freeze_warn <= 1'b0;
    end else begin
      freeze_warn <= warn_n;
    end
  end
`else
  assign freeze_warn = 1'b0;
`endif

  assign mode = state;

endmodule

// File: tb/tb_ghost_director.sv
// Directed bench for ghost_director with short phases (scatter 4, chase 6, fright 3, warn 1).
module tb_ghost_director;

  localparam logic [1:0] ID = 2'd0, SC = 2'd1, CH = 2'd2, FR = 2'd3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0, start = 1'b0, super_dot = 1'b0, ggShow = 1'b0;
  logic [7:0] rnd_dir;
  logic [2:0] AIpercent;
  logic       freeze, freeze_warn;
  logic [1:0] mode;

  logic        lrst = 1'b1;
  logic [15:0] lseed = 16'h0000;
  logic [15:0] lq;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  ghost_director #(
    .SCATTER_FRAMES (10'd4),
    .CHASE_FRAMES   (10'd6),
    .FREEZE_FRAMES  (10'd3),
    .WARN_FRAMES    (10'd1),
    .AI_LEVEL       (3'd5),
    .LFSR_SEED      (16'hACE1)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .start       (start),
    .super_dot   (super_dot),
    .ggShow      (ggShow),
    .rnd_dir     (rnd_dir),
    .AIpercent   (AIpercent),
    .freeze      (freeze),
    .freeze_warn (freeze_warn),
    .mode        (mode)
  );

  lfsr16 u_lfsr_chk (
    .Clk   (Clk),
    .Reset (lrst),
    .seed  (lseed),
    .q     (lq)
  );

  // Reference for rnd_dir: frame sampling and the LFSR sequence from seed ACE1.
  logic [15:0] m_lfsr;
  logic [2:0]  m_fs;
  logic [7:0]  exp_rnd;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_lfsr  <= 16'hACE1;
      m_fs    <= 3'b000;
      exp_rnd <= 8'd0;
    end else begin
      m_lfsr <= m_lfsr[0] ? ({1'b0, m_lfsr[15:1]} ^ 16'hB400) : {1'b0, m_lfsr[15:1]};
      m_fs   <= {m_fs[1:0], frame_clk};
      if (m_fs[1] && !m_fs[2] && !ggShow) exp_rnd <= m_lfsr[7:0];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_tick;
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic sd_pulse;
    @(negedge Clk) super_dot = 1'b1;
    repeat (2) @(negedge Clk);
    super_dot = 1'b0;
  endtask

  task automatic step(input logic [1:0] m, input logic w);
    logic ew;
`ifdef GHOST_DIR_FREEZE_WARN_EN
    ew = w;
`else
    ew = 1'b0;
`endif
    do_tick();
    chk("mode", {14'd0, mode}, {14'd0, m});
    chk("AIpercent", {13'd0, AIpercent}, (m == CH) ? 16'd5 : 16'd0);
    chk("freeze", {15'd0, freeze}, {15'd0, (m == FR)});
    chk("freeze_warn", {15'd0, freeze_warn}, {15'd0, ew});
    chk("rnd_dir", {8'd0, rnd_dir}, {8'd0, exp_rnd});
  endtask

  task automatic run(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) step(m, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_mode", {14'd0, mode}, 16'd0);
    chk("rst_rnd", {8'd0, rnd_dir}, 16'd0);
    chk("rst_ai", {13'd0, AIpercent}, 16'd0);
    chk("rst_freeze", {15'd0, freeze}, 16'd0);
    chk("rst_warn", {15'd0, freeze_warn}, 16'd0);
    Reset = 1'b0;

    run(1, ID);
    start = 1'b1;
    run(4, SC); run(6, CH); run(1, SC);
    run(3, SC); run(3, CH);
    // chase cnt=3: fright, then resume chase with cnt=2
    sd_pulse(); run(2, FR); step(FR, 1'b1); run(3, CH); run(1, SC);
    // re-trigger on the last fright frame
    sd_pulse(); run(2, FR); step(FR, 1'b1);
    sd_pulse(); run(2, FR); step(FR, 1'b1); run(1, SC);
    // trigger on scatter expiry: resume in a full chase
    run(2, SC); sd_pulse(); run(2, FR); step(FR, 1'b1); run(6, CH); run(1, SC);
    run(3, SC); run(2, CH);
    // game-over hold with a super dot latched but not consumed
    ggShow = 1'b1; sd_pulse(); run(10, CH);
    ggShow = 1'b0; run(2, FR); step(FR, 1'b1); run(4, CH); run(1, SC);
    start = 1'b0; run(1, SC);
    // async reset during fright
    sd_pulse(); run(1, FR);
    @(negedge Clk) Reset = 1'b1;
    #1;
    chk("arst_freeze", {15'd0, freeze}, 16'd0);
    chk("arst_mode", {14'd0, mode}, 16'd0);
    chk("arst_ai", {13'd0, AIpercent}, 16'd0);
    chk("arst_rnd", {8'd0, rnd_dir}, 16'd0);
    @(negedge Clk) Reset = 1'b0;

    // zero-lockup recovery on a standalone LFSR
    #1;
    chk("lfsr_zero", lq, 16'h0000);
    @(negedge Clk) begin lrst = 1'b0; lseed = 16'hACE1; end
    @(posedge Clk) #1;
    chk("lfsr_reload", lq, 16'hACE1);
    @(posedge Clk) #1;
    chk("lfsr_step1", lq, 16'hE270);
    @(posedge Clk) #1;
    chk("lfsr_step2", lq, 16'h7138);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
